// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered UART transmitter with baud divider and TX FIFO
//
// Purpose: queues words written at clock rate and sends them as UART frames
//          (start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits).
//          Frames leave back-to-back while words are queued.
// Optional feature macro: UART_TX_BREAK_EN (adds brk input and BREAK state).
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   wr_en     push wr_data this cycle
//   wr_data   word to transmit, LSB first
//   full      FIFO holds 2^FIFO_AW words
//   level     words queued, excluding the frame on the wire
//   overflow  one-cycle pulse after a write attempted while full
//   busy      high while a frame is in progress or words are queued
//   tx        registered serial line, idle high
//   brk       break request, honoured only in IDLE (UART_TX_BREAK_EN only)
module uart_tx_buffered #(
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 1,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_AW      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 full,
   output logic [FIFO_AW:0]     level,
   output logic                 overflow,
   output logic                 busy,
   output logic                 tx
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                 brk
`endif
);

   localparam int               DEPTH      = 1 << FIFO_AW;
   localparam int               CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]    CNT_MAX    = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);
   localparam logic [FIFO_AW:0] LEVEL_FULL = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic             PAR_ODD    = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
`ifdef UART_TX_BREAK_EN
      ,
      S_BREAK
`endif
   } state_t;

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [FIFO_AW-1:0]   wptr_q, rptr_q;
   logic [FIFO_AW:0]     level_q;
   logic                 overflow_q;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 push, pop, bit_done;
   logic [DATA_BITS-1:0] rd_word;

   assign full     = (level_q == LEVEL_FULL);
   assign level    = level_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != S_IDLE) || (level_q != '0);
   assign tx       = tx_q;
   assign push     = wr_en && !full;
   assign rd_word  = mem_q[rptr_q];
   assign bit_done = (cnt_q == CNT_MAX);

   // FIFO storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         overflow_q <= wr_en && full;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = bit_done ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      tx_d    = 1'b1;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
`ifdef UART_TX_BREAK_EN
            if (brk) state_d = S_BREAK;
            else
`endif
            if (level_q != '0) begin
               pop     = 1'b1;
               shift_d = rd_word;
               par_d   = (^rd_word) ^ PAR_ODD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (idx_q == LAST_DATA) begin
                  idx_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_done) begin
               idx_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               if (idx_q == LAST_STOP) begin
                  idx_d = '0;
                  // Chain straight into the next start bit when more data waits.
                  if (level_q != '0) begin
                     pop     = 1'b1;
                     shift_d = rd_word;
                     par_d   = (^rd_word) ^ PAR_ODD;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            cnt_d = '0;
            if (!brk) begin
               idx_d   = '0;
               state_d = S_STOP;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // tx is registered from the next state so the pin lines up with state_q.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
`ifdef UART_TX_BREAK_EN
         S_BREAK:  tx_d = 1'b0;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

endmodule
